// File: rtl/rompack_loader_arb_pkg.sv
// Shared types and constants for the PMD85 ROM-pack loader/arbiter.
//   ROMPACK_ADDR_W : ROM-pack address width (32 KB pack)
//   ROMPACK_INDEX  : hps_io download index that targets the ROM pack
//   rp_state_t     : load FSM states
//   rp_wr_t        : one buffered download byte {addr, data}
package pmd85_rompack_pkg;

   localparam int unsigned ROMPACK_ADDR_W = 15;
   localparam logic [7:0]  ROMPACK_INDEX  = 8'd1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DRAIN
   } rp_state_t;

   typedef struct packed {
      logic [ROMPACK_ADDR_W-1:0] addr;
      logic [7:0]                data;
   } rp_wr_t;

endpackage

// File: rtl/rompack_loader_arb_if.sv
// Bus bundle between hps_io download port, core read port and ROM-pack RAM.
//   ioctl_* : download stream in, ioctl_wait stall out
//   rd_*    : core read request/ack handshake
//   mem_*   : single-port byte RAM port (1-cycle read latency)
// Modport slave is the loader/arbiter view; master is the environment view.
interface rompack_loader_arb_if #(
   parameter int unsigned ADDR_W = 15
) ();

   logic              ioctl_download;
   logic [7:0]        ioctl_index;
   logic              ioctl_wr;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic              ioctl_wait;

   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_ack;
   logic [7:0]        rd_data;

   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_we;
   logic [7:0]        mem_rdata;

   modport slave (
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      output ioctl_wait,
      input  rd_req, rd_addr,
      output rd_ack, rd_data,
      output mem_addr, mem_wdata, mem_we,
      input  mem_rdata
   );

   modport master (
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      input  ioctl_wait,
      output rd_req, rd_addr,
      input  rd_ack, rd_data,
      input  mem_addr, mem_wdata, mem_we,
      output mem_rdata
   );

endinterface

// File: rtl/rompack_loader_arb_wr_fifo.sv
// Write buffer for download bytes.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : synchronous empty (wins over push/pop)
//   push/push_data, pop/head : enqueue / dequeue, head is the oldest entry
//   count, full, empty : occupancy
module rompack_wr_fifo
   import pmd85_rompack_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          push,
   input  rp_wr_t                        push_data,
   input  logic                          pop,
   output rp_wr_t                        head,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          full,
   output logic                          empty
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);

   rp_wr_t         store [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign full    = (count == (PW+1)'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign head    = store[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) store[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rompack_loader_arb.sv
// PMD85 ROM-pack loader and RAM arbiter.
//   clk_sys, reset : system clock, asynchronous active-high reset
//   bus            : ioctl download, core read port and RAM port (slave view)
//   pack_valid     : a complete pack has been loaded
//   pack_size      : highest written address + 1 (saturates at 2^ADDR_W)
//   overflow       : sticky, a byte was dropped during the current load
//   led_busy       : load or drain in progress
module rompack_loader_arb
   import pmd85_rompack_pkg::*;
#(
   parameter int unsigned ADDR_W     = ROMPACK_ADDR_W,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [7:0]  ROM_INDEX  = ROMPACK_INDEX
) (
   input  logic                clk_sys,
   input  logic                reset,
   rompack_loader_arb_if.slave bus,
   output logic                pack_valid,
   output logic [ADDR_W:0]     pack_size,
   output logic                overflow,
   output logic                led_busy
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] HI_WATER = CW'(FIFO_DEPTH - 1);

   rp_state_t     state, state_n;
   logic          dl_prev, dl_now, dl_start, flush;
   logic          in_range, wr_take, push, drop;
   logic          fifo_full, fifo_empty, pop;
   logic [CW-1:0] fifo_count, count_n;
   rp_wr_t        fifo_head, push_data;
   logic [ADDR_W:0] wr_end;

   logic rd_armed, rd_ph1, rd_ph2, ff_pend;
   logic rd_issue, rd_hit, rd_grant, rd_ff, pop_first;

   assign dl_now    = bus.ioctl_download && (bus.ioctl_index == ROM_INDEX);
   assign dl_start  = dl_now && !dl_prev;
   assign flush     = dl_start && (state == IDLE);
   assign in_range  = (bus.ioctl_addr[24:ADDR_W] == '0);
   assign wr_take   = (state == LOAD) && bus.ioctl_wr;
   assign push      = wr_take && in_range && !fifo_full;
   assign drop      = wr_take && !push;
   assign push_data = '{addr: bus.ioctl_addr[ADDR_W-1:0], data: bus.ioctl_dout};
   assign wr_end    = {1'b0, bus.ioctl_addr[ADDR_W-1:0]} + 1'b1;

   // A read is taken once per request: rd_armed drops on issue and only
   // re-arms after rd_req has been seen low.
   assign rd_issue  = bus.rd_req && rd_armed && !(rd_ph1 || rd_ph2 || ff_pend);
   assign rd_hit    = ({1'b0, bus.rd_addr} < pack_size);
   assign pop_first = (fifo_count >= HI_WATER);
   assign rd_grant  = rd_issue && rd_hit && !pop_first;
   assign rd_ff     = rd_issue && !rd_hit;
   assign pop       = !fifo_empty && !rd_grant;

   rompack_wr_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk_sys),
      .rst       (reset),
      .flush     (flush),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      count_n = fifo_count;
      if (push) count_n = count_n + 1'b1;
      if (pop)  count_n = count_n - 1'b1;
      if (flush) count_n = '0;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (dl_start) state_n = LOAD;
         LOAD:    if (!bus.ioctl_download) state_n = DRAIN;
         // The last popped byte is in flight while mem_we is high.
         DRAIN:   if (fifo_empty && !bus.mem_we) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Load FSM and status outputs. dl_prev resets high so a download already
   // active when reset is released needs a fresh rising edge.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         dl_prev        <= 1'b1;
         led_busy       <= 1'b0;
         bus.ioctl_wait <= 1'b0;
         pack_valid     <= 1'b0;
         pack_size      <= '0;
         overflow       <= 1'b0;
      end else begin
         state          <= state_n;
         dl_prev        <= dl_now;
         led_busy       <= (state_n != IDLE);
         bus.ioctl_wait <= (state_n == LOAD) && (count_n >= HI_WATER);
         if (flush) begin
            pack_valid <= 1'b0;
            pack_size  <= '0;
            overflow   <= 1'b0;
         end
         if (push && (wr_end > pack_size)) pack_size <= wr_end;
         if (drop) overflow <= 1'b1;
         if ((state == DRAIN) && (state_n == IDLE)) pack_valid <= 1'b1;
      end
   end

   // Memory port and read pipeline: grant (k) -> RAM samples (k+1) -> ack (k+2).
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         rd_armed      <= 1'b1;
         rd_ph1        <= 1'b0;
         rd_ph2        <= 1'b0;
         ff_pend       <= 1'b0;
         bus.rd_ack    <= 1'b0;
         bus.rd_data   <= 8'hFF;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_we    <= 1'b0;
      end else begin
         bus.rd_ack <= 1'b0;
         bus.mem_we <= 1'b0;
         if (!bus.rd_req) rd_armed <= 1'b1;
         if (rd_issue)    rd_armed <= 1'b0;
         rd_ph1  <= rd_grant;
         rd_ph2  <= rd_ph1;
         ff_pend <= rd_ff;
         if (rd_ph2) begin
            bus.rd_data <= bus.mem_rdata;
            bus.rd_ack  <= 1'b1;
         end
         if (ff_pend) begin
            bus.rd_data <= 8'hFF;
            bus.rd_ack  <= 1'b1;
         end
         if (rd_grant) begin
            bus.mem_addr <= bus.rd_addr;
         end else if (pop) begin
            bus.mem_addr  <= fifo_head.addr;
            bus.mem_wdata <= fifo_head.data;
            bus.mem_we    <= 1'b1;
         end
      end
   end

endmodule
